// File: rtl/sha256_pkg.sv
// sha256_pkg: round constants, initial hash, FSM state type and the
// combinational primitives shared by the round engine and its message schedule.
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_FINAL = 2'd3
    } state_t;

    // Working variables a..h; a occupies the top word of the packed struct.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    localparam int NUM_ROUNDS = 64;

    // FIPS 180-4 initial hash, H0 in bits [31:0].
    localparam logic [255:0] H_INIT =
        256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // One compression round; all sums wrap at 32 bits.
    function automatic work_t sha256_round(input work_t s, input logic [31:0] k, input logic [31:0] w);
        logic [31:0] t1;
        logic [31:0] t2;
        work_t       n;
        t1  = s.h + big_sigma1(s.e) + ch(s.e, s.f, s.g) + k + w;
        t2  = big_sigma0(s.a) + maj(s.a, s.b, s.c);
        n.a = t1 + t2;
        n.b = s.a;
        n.c = s.b;
        n.d = s.c;
        n.e = s.d + t1;
        n.f = s.e;
        n.g = s.f;
        n.h = s.g;
        return n;
    endfunction

    // Chaining value (H0 in the low word) to working variables.
    function automatic work_t unpack_chain(input logic [255:0] v);
        work_t s;
        s.a = v[31:0];
        s.b = v[63:32];
        s.c = v[95:64];
        s.d = v[127:96];
        s.e = v[159:128];
        s.f = v[191:160];
        s.g = v[223:192];
        s.h = v[255:224];
        return s;
    endfunction

    // Final feed-forward: chaining value plus working variables, word-wise.
    function automatic logic [255:0] add_chain(input logic [255:0] v, input work_t s);
        logic [255:0] r;
        r[31:0]    = v[31:0]    + s.a;
        r[63:32]   = v[63:32]   + s.b;
        r[95:64]   = v[95:64]   + s.c;
        r[127:96]  = v[127:96]  + s.d;
        r[159:128] = v[159:128] + s.e;
        r[191:160] = v[191:160] + s.f;
        r[223:192] = v[223:192] + s.g;
        r[255:224] = v[255:224] + s.h;
        return r;
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: 16-word rolling message schedule. The window always holds
// W[t]..W[t+15]; each advance emits W[t]..W[t+R-1] and shifts in R new words.
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           halt,
    input  logic                           clear,
    input  logic                           i_load,
    input  logic [511:0]                   i_block,
    input  logic                           i_advance,
    output logic [32*ROUNDS_PER_CYCLE-1:0] o_words
);

    logic [31:0]                   r_win [16];
    logic [31:0]                   w_shifted [16];
    logic [32*ROUNDS_PER_CYCLE-1:0] w_new_all;

    // New schedule words; later words chain off earlier new words in the same cycle.
    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : gen_w
        logic [31:0] w_m2;
        logic [31:0] w_m7;
        logic [31:0] w_new;
        if (j < 2) begin : g_m2_win
            assign w_m2 = r_win[14+j];
        end else begin : g_m2_new
            assign w_m2 = gen_w[j-2].w_new;
        end
        if (j < 7) begin : g_m7_win
            assign w_m7 = r_win[9+j];
        end else begin : g_m7_new
            assign w_m7 = gen_w[j-7].w_new;
        end
        assign w_new                  = small_sigma1(w_m2) + w_m7 + small_sigma0(r_win[1+j]) + r_win[j];
        assign w_new_all[32*j +: 32]  = w_new;
        assign o_words[32*j +: 32]    = r_win[j];
    end

    // Window contents after shifting by R words.
    for (genvar i = 0; i < 16; i++) begin : gen_shift
        if (i + ROUNDS_PER_CYCLE < 16) begin : g_old
            assign w_shifted[i] = r_win[i+ROUNDS_PER_CYCLE];
        end else begin : g_new
            assign w_shifted[i] = w_new_all[32*(i+ROUNDS_PER_CYCLE-16) +: 32];
        end
    end

    // Window register: reset/clear zero it, halt freezes it, load captures the block.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < 16; i++) r_win[i] <= '0;
        end else if (!halt) begin
            if (i_load) begin
                for (int i = 0; i < 16; i++) r_win[i] <= i_block[32*i +: 32];
            end else if (i_advance) begin
                for (int i = 0; i < 16; i++) r_win[i] <= w_shifted[i];
            end
        end
    end

endmodule

// File: rtl/sha256_round_engine.sv
// sha256_round_engine: single-block SHA-256 compression, ROUNDS_PER_CYCLE
// rounds per clock, optional midstate chaining.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for start; block/chaining value captured on accept
//   ST_LOAD  | a..h loaded from chaining value, round counter cleared
//   ST_ROUND | R rounds per cycle until the counter reaches 64
//   ST_FINAL | hash <= chaining value + a..h, done pulses next cycle
module sha256_round_engine
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter bit ZERO_ON_CLEAR    = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         halt,
    input  logic         clear,
    input  logic         use_midstate,
    input  logic [511:0] block,
    input  logic [255:0] midstate_in,
    output logic         busy,
    output logic         done,
    output logic [255:0] hash
);

    state_t                          r_state;
    logic [6:0]                      r_cnt;
    work_t                           r_work;
    logic [255:0]                    r_chain;
    logic [255:0]                    r_hash;
    logic                            r_busy;
    logic                            r_done;

    logic                            w_load;
    logic                            w_advance;
    logic [32*ROUNDS_PER_CYCLE-1:0]  w_words;
    logic [6:0]                      w_cnt_next;
    work_t                           w_work_next;

    assign w_load     = (r_state == ST_IDLE) && start;
    assign w_advance  = (r_state == ST_ROUND);
    assign w_cnt_next = r_cnt + 7'(ROUNDS_PER_CYCLE);

    sha256_msg_sched #(
        .ROUNDS_PER_CYCLE (ROUNDS_PER_CYCLE)
    ) u_sched (
        .clk       (clk),
        .rst       (rst),
        .halt      (halt),
        .clear     (clear),
        .i_load    (w_load),
        .i_block   (block),
        .i_advance (w_advance),
        .o_words   (w_words)
    );

    // Unrolled rounds for one cycle; only the last stage is registered.
    for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : gen_rnd
        work_t      w_in;
        work_t      w_out;
        logic [5:0] w_kidx;
        if (k == 0) begin : g_first
            assign w_in = r_work;
        end else begin : g_chain
            assign w_in = gen_rnd[k-1].w_out;
        end
        assign w_kidx = r_cnt[5:0] + 6'(k);
        assign w_out  = sha256_round(w_in, K[w_kidx], w_words[32*k +: 32]);
    end

    assign w_work_next = gen_rnd[ROUNDS_PER_CYCLE-1].w_out;

    // Control FSM with registered busy/done; rst beats clear beats halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_work  <= '0;
            r_chain <= '0;
            r_hash  <= '0;
        end else if (clear) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            if (ZERO_ON_CLEAR) r_hash <= '0;
        end else if (!halt) begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_chain <= use_midstate ? midstate_in : H_INIT;
                        r_busy  <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_work  <= unpack_chain(r_chain);
                    r_cnt   <= '0;
                    r_state <= ST_ROUND;
                end
                ST_ROUND: begin
                    r_work <= w_work_next;
                    r_cnt  <= w_cnt_next;
                    if (w_cnt_next == 7'(NUM_ROUNDS)) r_state <= ST_FINAL;
                end
                ST_FINAL: begin
                    r_hash  <= add_chain(r_chain, r_work);
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hash = r_hash;

endmodule

// File: tb/tb_sha256_round_engine.sv
// Bench for sha256_round_engine: R=1 instance for the functional scenarios,
// R=4 and R=8 instances sharing a second stimulus set for the latency check.
module tb_sha256_round_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, halt, clear, use_midstate;
    logic [511:0] block;
    logic [255:0] midstate_in;
    logic         busy, done;
    logic [255:0] hash;

    logic         m_rst, m_start;
    logic [511:0] m_block;
    logic         busy4, done4, busy8, done8;
    logic [255:0] hash4, hash8;

    int n_tests = 0;
    int n_fail  = 0;
    logic [255:0] exp_q [$];

    localparam logic [255:0] IV       = 256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;
    localparam logic [255:0] ABC_HASH = 256'hf20015ad_b410ff61_96177a9c_b00361a3_5dae2223_414140de_8f01cfea_ba7816bf;
    localparam logic [255:0] TWO_HASH = 256'h19db06c1_f6ecedd4_64ff2167_a33ce459_0c3e6039_e5c02693_d20638b8_248d6a61;
    localparam logic [511:0] ABC_BLK  = {32'h00000018, 448'h0, 32'h61626380};

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    sha256_round_engine #(.ROUNDS_PER_CYCLE(1), .ZERO_ON_CLEAR(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .clear(clear),
        .use_midstate(use_midstate), .block(block), .midstate_in(midstate_in),
        .busy(busy), .done(done), .hash(hash)
    );

    sha256_round_engine #(.ROUNDS_PER_CYCLE(4), .ZERO_ON_CLEAR(1'b1)) dut4 (
        .clk(clk), .rst(m_rst), .start(m_start), .halt(1'b0), .clear(1'b0),
        .use_midstate(1'b0), .block(m_block), .midstate_in(256'h0),
        .busy(busy4), .done(done4), .hash(hash4)
    );

    sha256_round_engine #(.ROUNDS_PER_CYCLE(8), .ZERO_ON_CLEAR(1'b1)) dut8 (
        .clk(clk), .rst(m_rst), .start(m_start), .halt(1'b0), .clear(1'b0),
        .use_midstate(1'b0), .block(m_block), .midstate_in(256'h0),
        .busy(busy8), .done(done8), .hash(hash8)
    );

    // ---------------- reference model (64-word schedule array) ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] ref_compress(input logic [511:0] blk, input logic [255:0] hin);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[32*t +: 32];
        for (int t = 16; t < 64; t++) begin
            s0   = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hin[32*i +: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[32*i +: 32] = hin[32*i +: 32] + v[i];
        return r;
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [255:0] rand_mid();
        logic [255:0] m;
        for (int i = 0; i < 8; i++) m[32*i +: 32] = $urandom;
        return m;
    endfunction

    function automatic logic [511:0] mk_blk1();
        logic [511:0] b;
        logic [7:0]   c;
        b = '0;
        for (int i = 0; i < 14; i++) begin
            c = 8'h61 + 8'(i);
            b[32*i +: 32] = {c, c + 8'd1, c + 8'd2, c + 8'd3};
        end
        b[32*14 +: 32] = 32'h80000000;
        return b;
    endfunction

    // ---------------- stimulus helpers (called at a negedge, return at a negedge) ----------------
    task automatic drive_start(input logic [511:0] blk, input logic um, input logic [255:0] mid);
        block = blk; use_midstate = um; midstate_in = mid; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        block = ~blk; use_midstate = ~um; midstate_in = ~mid;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; m_rst = 1'b1; start = 1'b0; halt = 1'b0; clear = 1'b0;
        use_midstate = 1'b0; block = '0; midstate_in = '0; m_start = 1'b0; m_block = '0;
        repeat (3) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (hash !== 256'h0) begin n_fail++; $display("FAIL reset_hash: got %h want 0", hash); end
        rst = 1'b0; m_rst = 1'b0;
    endtask

    task automatic test_abc();
        int lat;
        logic [255:0] exp;
        exp_q.push_back(ABC_HASH);
        drive_start(ABC_BLK, 1'b0, rand_mid());
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abc_busy: got %b want 1", busy); end
        wait_done(100, lat);
        exp = exp_q.pop_front();
        n_tests++; if (lat !== 66) begin n_fail++; $display("FAIL abc_latency: got %0d want 66", lat); end
        n_tests++; if (hash !== exp) begin n_fail++; $display("FAIL abc_hash: got %h want %h", hash, exp); end
        @(negedge clk);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL abc_done_width: got %b want 0", done); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abc_busy_after: got %b want 0", busy); end
        repeat (5) @(negedge clk);
        n_tests++; if (hash !== exp) begin n_fail++; $display("FAIL abc_hash_hold: got %h want %h", hash, exp); end
    endtask

    task automatic test_start_while_busy();
        int lat;
        logic [255:0] exp;
        exp_q.push_back(ABC_HASH);
        drive_start(ABC_BLK, 1'b0, '0);
        repeat (10) @(negedge clk);
        drive_start(rand_blk(), 1'b1, rand_mid());
        wait_done(100, lat);
        exp = exp_q.pop_front();
        n_tests++; if (lat + 11 !== 66) begin n_fail++; $display("FAIL busy_start_latency: got %0d want 66", lat + 11); end
        n_tests++; if (hash !== exp) begin n_fail++; $display("FAIL busy_start_hash: got %h want %h", hash, exp); end
        wait_done(80, lat);
        n_tests++; if (lat !== -1) begin n_fail++; $display("FAIL busy_start_extra_done: got done at %0d want none", lat); end
    endtask

    task automatic test_two_block();
        int lat;
        logic [255:0] exp, h1;
        logic [511:0] b1, b2;
        b1 = mk_blk1();
        b2 = {32'h000001c0, 480'h0};
        h1 = ref_compress(b1, IV);
        exp_q.push_back(h1);
        drive_start(b1, 1'b0, rand_mid());
        wait_done(100, lat);
        exp = exp_q.pop_front();
        n_tests++; if (hash !== exp) begin n_fail++; $display("FAIL two_block_h1: got %h want %h", hash, exp); end
        exp_q.push_back(TWO_HASH);
        drive_start(b2, 1'b1, h1);
        wait_done(100, lat);
        exp = exp_q.pop_front();
        n_tests++; if (lat !== 66) begin n_fail++; $display("FAIL two_block_latency: got %0d want 66", lat); end
        n_tests++; if (hash !== exp) begin n_fail++; $display("FAIL two_block_hash: got %h want %h", hash, exp); end
    endtask

    task automatic test_random();
        int lat;
        logic [255:0] exp, mid;
        logic [511:0] b;
        logic um;
        for (int i = 0; i < 3; i++) begin
            b = rand_blk(); mid = rand_mid(); um = 1'($urandom_range(0, 1));
            exp_q.push_back(ref_compress(b, um ? mid : IV));
            drive_start(b, um, mid);
            wait_done(100, lat);
            exp = exp_q.pop_front();
            n_tests++; if (hash !== exp) begin n_fail++; $display("FAIL random_hash[%0d]: got %h want %h", i, hash, exp); end
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        int lat;
        logic [255:0] exp;
        exp_q.push_back(ABC_HASH);
        drive_start(ABC_BLK, 1'b0, '0);
        repeat (21) @(negedge clk);
        halt = 1'b1;
        repeat (5) @(negedge clk);
        halt = 1'b0;
        wait_done(100, lat);
        exp = exp_q.pop_front();
        n_tests++; if (lat + 26 !== 71) begin n_fail++; $display("FAIL halt_latency: got %0d want 71", lat + 26); end
        n_tests++; if (hash !== exp) begin n_fail++; $display("FAIL halt_hash: got %h want %h", hash, exp); end
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL halt_done_extend[%0d]: got %b want 1", i, done); end
        end
        halt = 1'b0;
        @(negedge clk);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL halt_done_release: got %b want 0", done); end
    endtask

    task automatic test_clear();
        int lat;
        logic [255:0] exp;
        start = 1'b1; clear = 1'b1; block = ABC_BLK;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_over_start: got busy %b want 0", busy); end
        start = 1'b1; halt = 1'b1;
        @(negedge clk);
        start = 1'b0; halt = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL halt_blocks_start: got busy %b want 0", busy); end
        drive_start(ABC_BLK, 1'b0, '0);
        repeat (31) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL clear_done: got %b want 0", done); end
        n_tests++; if (hash !== 256'h0) begin n_fail++; $display("FAIL clear_hash: got %h want 0", hash); end
        wait_done(80, lat);
        n_tests++; if (lat !== -1) begin n_fail++; $display("FAIL clear_no_done: got done at %0d want none", lat); end
        exp_q.push_back(ABC_HASH);
        drive_start(ABC_BLK, 1'b0, '0);
        wait_done(100, lat);
        exp = exp_q.pop_front();
        n_tests++; if (lat !== 66) begin n_fail++; $display("FAIL clear_restart_latency: got %0d want 66", lat); end
        n_tests++; if (hash !== exp) begin n_fail++; $display("FAIL clear_restart_hash: got %h want %h", hash, exp); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [255:0] exp;
        logic [511:0] b1, b2;
        b1 = rand_blk(); b2 = rand_blk();
        exp_q.push_back(ref_compress(b1, IV));
        drive_start(b1, 1'b0, '0);
        wait_done(100, lat);
        exp = exp_q.pop_front();
        n_tests++; if (hash !== exp) begin n_fail++; $display("FAIL b2b_first_hash: got %h want %h", hash, exp); end
        exp_q.push_back(ref_compress(b2, IV));
        drive_start(b2, 1'b0, '0);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop: got %b want 0", done); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy %b want 1", busy); end
        wait_done(100, lat);
        exp = exp_q.pop_front();
        n_tests++; if (lat !== 66) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 66", lat); end
        n_tests++; if (hash !== exp) begin n_fail++; $display("FAIL b2b_second_hash: got %h want %h", hash, exp); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [255:0] exp;
        exp_q.push_back(ref_compress(rand_blk(), IV));
        drive_start(rand_blk(), 1'b0, '0);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b want 0", done); end
        n_tests++; if (hash !== 256'h0) begin n_fail++; $display("FAIL rst_mid_hash: got %h want 0", hash); end
        rst = 1'b0;
        wait_done(80, lat);
        n_tests++; if (lat !== -1) begin n_fail++; $display("FAIL rst_mid_no_done: got done at %0d want none", lat); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(ABC_HASH);
        drive_start(ABC_BLK, 1'b0, '0);
        wait_done(100, lat);
        exp = exp_q.pop_front();
        n_tests++; if (lat !== 66) begin n_fail++; $display("FAIL rst_restart_latency: got %0d want 66", lat); end
        n_tests++; if (hash !== exp) begin n_fail++; $display("FAIL rst_restart_hash: got %h want %h", hash, exp); end
    endtask

    task automatic test_rates();
        int lat4, lat8;
        lat4 = -1; lat8 = -1;
        m_block = ABC_BLK; m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0; m_block = '0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done4 && lat4 < 0) lat4 = n;
            if (done8 && lat8 < 0) lat8 = n;
        end
        n_tests++; if (lat4 !== 18) begin n_fail++; $display("FAIL r4_latency: got %0d want 18", lat4); end
        n_tests++; if (hash4 !== ABC_HASH) begin n_fail++; $display("FAIL r4_hash: got %h want %h", hash4, ABC_HASH); end
        n_tests++; if (lat8 !== 10) begin n_fail++; $display("FAIL r8_latency: got %0d want 10", lat8); end
        n_tests++; if (hash8 !== ABC_HASH) begin n_fail++; $display("FAIL r8_hash: got %h want %h", hash8, ABC_HASH); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_abc();
        test_start_while_busy();
        test_two_block();
        test_random();
        test_halt();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        test_rates();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached with %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sha256_round_engine.md
SHA256_ROUND_ENGINE -- requirements
Module: sha256_round_engine

Interface
REQ-001 Parameter ROUNDS_PER_CYCLE, default 1, SHA-256 rounds per clock; legal values 1, 2, 4, 8.
REQ-002 Parameter ZERO_ON_CLEAR, default 1, when 1 clear also zeroes hash.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to compress block; accepted only in IDLE.
REQ-006 halt  input  1  freezes all internal state while high.
REQ-007 clear  input  1  synchronous abort to IDLE.
REQ-008 use_midstate  input  1  1: chaining value = midstate_in; 0: FIPS 180-4 initial H.
REQ-009 block  input  512  message block; word i at bits [32i+31:32i], word 0 is W0.
REQ-010 midstate_in  input  256  chaining value; H0 at bits [31:0].
REQ-011 busy  output  1  high in LOAD, ROUND, FINAL.
REQ-012 done  output  1  one-cycle pulse when hash valid.
REQ-013 hash  output  256  result; H0 at bits [31:0], H7 at [255:224].

Function
REQ-014 FSM states IDLE, LOAD, ROUND, FINAL; DONE is not a state, done is a registered pulse.
REQ-015 IDLE: start=1 -> LOAD; block, midstate_in, use_midstate captured that edge.
REQ-016 LOAD: a..h and chaining value loaded, round counter = 0 -> ROUND, one cycle.
REQ-017 ROUND: ROUNDS_PER_CYCLE rounds per cycle, counter += ROUNDS_PER_CYCLE; after 64 rounds -> FINAL.
REQ-018 FINAL: hash <= chaining value + a..h, word-wise mod 2^32; done=1 next cycle; -> IDLE.
REQ-019 Latency: done high exactly 64/ROUNDS_PER_CYCLE + 2 cycles after the edge that sampled start (66 for R=1, 10 for R=8), excluding halted cycles.
REQ-020 hash holds its value until the next FINAL, clear (ZERO_ON_CLEAR=1), or rst.
REQ-021 start while busy ignored; start in the done-pulse cycle accepted (back-to-back).
REQ-022 halt=1: state, counter, a..h, W window, hash, done all hold; a pending done pulse is extended for the halted cycles.
REQ-023 clear=1: -> IDLE, busy=0, done=0, counter=0; overrides start and halt in the same cycle.
REQ-024 rst overrides clear, halt, start.
REQ-025 Round counter 7 bits; terminal compare at 64, no wrap past 64.
REQ-026 Message schedule: 16-word rolling window, W computed on the fly; no 64-word array.
REQ-027 All additions 32-bit modular; no carry out retained.

Reset
REQ-028 On rst: state IDLE, busy 0, done 0, hash 0, counter 0, a..h 0, window 0.
REQ-029 rst mid-operation discards the block; no done pulse produced for it.
REQ-030 First start accepted the cycle after rst deasserts.

Structure
REQ-031 Package sha256_pkg: K[0:63] constants, FIPS initial H, state enum, functions ch, maj, Sigma0/1, sigma0/1.
REQ-032 Sub-module sha256_msg_sched: 16-word window, emits ROUNDS_PER_CYCLE W words per advance; shares halt/clear.
REQ-033 Round logic is a generate loop of ROUNDS_PER_CYCLE combinational rounds; single register stage per cycle.

Verification
REQ-034 R=1, block "abc" (W0=61626380, W15=00000018), use_midstate=0 -> done at cycle 66; hash H0..H7 = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-035 R=4, same block -> identical hash, done at cycle 18; R=8 -> cycle 10.
REQ-036 Two-block 448-bit "abcdbcdecdefdefg...nopq": block 1, then block 2 with use_midstate=1, midstate_in = block-1 hash -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-037 "abc", halt high 5 cycles at round 20 -> done at cycle 71, hash unchanged from REQ-034.
REQ-038 clear at round 30 -> busy 0 next cycle, no done, hash 0; new start then yields correct hash at normal latency.
REQ-039 Back-to-back: start asserted during done pulse, and rst asserted mid-round -> second hash correct; after rst all outputs 0, no done.
